// File: rtl/edp_fm_slice_12to17.sv
// Fast-memory (AC block) storage slice for EDP bits 12-17: 128 x {6 data, 1 odd parity}.
// A power-up scrub fills every word with good parity, then a one-deep write buffer feeds the RAM.
module edp_fm_slice_12to17 #(
    parameter int WORDS  = 128,
    parameter int DATA_W = 6
) (
    input  logic              clk_edp_12_h,
    input  logic              reset_l,
    input  logic              apr_fm_block_1_h,
    input  logic              apr_fm_block_2_h,
    input  logic              apr_fm_block_4_h,
    input  logic              apr_fm_adr_1_h,
    input  logic              apr_fm_adr_2_h,
    input  logic              apr_fm_adr_4_h,
    input  logic              apr_fm_adr_10_h,
    input  logic              con_fm_write_00to17_l,
    input  logic [DATA_W-1:0] ar_12to17_h,
    input  logic              diag_fm_par_force_h,
    input  logic              diag_clr_par_err_h,
    output logic [DATA_W-1:0] fm_12to17_h,
    output logic              fm_parity_12to17_h,
    output logic              fm_par_err_12to17_h,
    output logic              fm_init_busy_h
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [6:0]      scrub_cnt;
    logic [6:0]      addr;

    // Each word is {data, stored parity}; parity in bit 0.
    logic [DATA_W:0] mem [0:WORDS-1];

    logic            wb_valid;
    logic [6:0]      wb_addr;
    logic [DATA_W:0] wb_word;

    logic            capture;
    logic [DATA_W:0] cap_word;
    logic            mem_we;
    logic [6:0]      mem_waddr;
    logic [DATA_W:0] mem_wdata;
    logic [DATA_W:0] rd_word;
    logic            rd_bad;

    assign addr = {apr_fm_block_4_h, apr_fm_block_2_h, apr_fm_block_1_h,
                   apr_fm_adr_10_h, apr_fm_adr_4_h, apr_fm_adr_2_h, apr_fm_adr_1_h};

    assign fm_init_busy_h = (state == ST_INIT);

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (scrub_cnt == 7'd127) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_edp_12_h or negedge reset_l) begin
        if (!reset_l) begin
            state     <= ST_INIT;
            scrub_cnt <= 7'd0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) scrub_cnt <= scrub_cnt + 7'd1;
        end
    end

    // Stored parity makes the 7-bit word odd; the diag force flips it to plant an error.
    assign capture  = (state == ST_RUN) && !con_fm_write_00to17_l;
    assign cap_word = {ar_12to17_h, (~^ar_12to17_h) ^ diag_fm_par_force_h};

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_addr;
        mem_wdata = wb_word;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = scrub_cnt;
            mem_wdata = {{DATA_W{1'b0}}, 1'b1};
        end else if (wb_valid) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk_edp_12_h) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // The buffer still holds a write the RAM has not absorbed yet, so it overrides the array.
    assign rd_word = (wb_valid && (wb_addr == addr)) ? wb_word : mem[addr];
    assign rd_bad  = ~(^rd_word);

    always_ff @(posedge clk_edp_12_h or negedge reset_l) begin
        if (!reset_l) begin
            wb_valid            <= 1'b0;
            wb_addr             <= 7'd0;
            wb_word             <= '0;
            fm_12to17_h         <= '0;
            fm_parity_12to17_h  <= 1'b1;
            fm_par_err_12to17_h <= 1'b0;
        end else begin
            wb_valid <= capture;
            if (capture) begin
                wb_addr <= addr;
                wb_word <= cap_word;
            end
            if (state == ST_RUN) begin
                fm_12to17_h        <= rd_word[DATA_W:1];
                fm_parity_12to17_h <= rd_word[0];
            end else begin
                fm_12to17_h        <= '0;
                fm_parity_12to17_h <= 1'b1;
            end
            if ((state == ST_RUN) && rd_bad) fm_par_err_12to17_h <= 1'b1;
            else if (diag_clr_par_err_h)     fm_par_err_12to17_h <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edp_fm_slice_12to17.sv
// Directed bench for the EDP bits 12-17 fast-memory slice: scrub, write/read, forwarding, parity error.
module tb_edp_fm_slice_12to17;

  logic       clk;
  logic       reset_l;
  logic       blk1, blk2, blk4, a1, a2, a4, a10;
  logic       wr_l;
  logic [5:0] ar;
  logic       par_force;
  logic       clr_err;
  logic [5:0] fm;
  logic       fm_par;
  logic       fm_err;
  logic       busy;

  int checks;
  int errors;
  int n;

  edp_fm_slice_12to17 dut (
    .clk_edp_12_h          (clk),
    .reset_l               (reset_l),
    .apr_fm_block_1_h      (blk1),
    .apr_fm_block_2_h      (blk2),
    .apr_fm_block_4_h      (blk4),
    .apr_fm_adr_1_h        (a1),
    .apr_fm_adr_2_h        (a2),
    .apr_fm_adr_4_h        (a4),
    .apr_fm_adr_10_h       (a10),
    .con_fm_write_00to17_l (wr_l),
    .ar_12to17_h           (ar),
    .diag_fm_par_force_h   (par_force),
    .diag_clr_par_err_h    (clr_err),
    .fm_12to17_h           (fm),
    .fm_parity_12to17_h    (fm_par),
    .fm_par_err_12to17_h   (fm_err),
    .fm_init_busy_h        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [6:0] a);
    {blk4, blk2, blk1, a10, a4, a2, a1} = a;
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [5:0] d, input logic p, input logic e);
    check({tag, " data"}, {2'b0, fm}, {2'b0, d});
    check({tag, " par"}, {7'b0, fm_par}, {7'b0, p});
    check({tag, " err"}, {7'b0, fm_err}, {7'b0, e});
  endtask

  // Count edges until busy drops, bounded so a stuck scrub still reaches the summary.
  task automatic count_busy(output int edges);
    edges = 0;
    while (busy === 1'b1 && edges < 300) begin
      step();
      edges++;
    end
  endtask

  initial begin
    logic [5:0] bb_data [4];
    logic       bb_par  [4];
    checks = 0;
    errors = 0;
    reset_l = 1'b0;
    set_addr(7'h00);
    wr_l = 1'b1;
    ar = 6'o00;
    par_force = 1'b0;
    clr_err = 1'b0;
    repeat (3) step();
    check_word("reset", 6'o00, 1'b1, 1'b0);
    check("reset busy", {7'b0, busy}, 8'h01);

    // 1: scrub with the write strobe held active; nothing may land.
    wr_l = 1'b0;
    ar = 6'o77;
    set_addr(7'h35);
    reset_l = 1'b1;
    step();
    check_word("init hold", 6'o00, 1'b1, 1'b0);
    check("init busy", {7'b0, busy}, 8'h01);
    count_busy(n);
    wr_l = 1'b1;
    check("init edges", n[7:0], 8'd127);
    for (int i = 0; i < 128; i++) begin
      set_addr(i[6:0]);
      step();
      check_word("scrubbed", 6'o00, 1'b1, 1'b0);
    end

    // 2: write 52 to 0x35, read back forwarded then from RAM.
    set_addr(7'h35);
    ar = 6'o52;
    wr_l = 1'b0;
    step();
    wr_l = 1'b1;
    ar = 6'o00;
    step();
    check_word("wr35 fwd", 6'o52, 1'b0, 1'b0);
    step();
    check_word("wr35 ram", 6'o52, 1'b0, 1'b0);

    // 3: read-before-write on the capture edge, forwarding the next edge.
    set_addr(7'h10);
    ar = 6'o77;
    wr_l = 1'b0;
    step();
    check_word("rbw old", 6'o00, 1'b1, 1'b0);
    wr_l = 1'b1;
    step();
    check_word("rbw new", 6'o77, 1'b1, 1'b0);

    // 4: forced bad parity at 0x20, sticky error, set beats clear, lone clear.
    set_addr(7'h20);
    ar = 6'o01;
    par_force = 1'b1;
    wr_l = 1'b0;
    step();
    check("err before bad", {7'b0, fm_err}, 8'h00);
    par_force = 1'b0;
    wr_l = 1'b1;
    step();
    check_word("bad fwd", 6'o01, 1'b1, 1'b1);
    set_addr(7'h35);
    step();
    check_word("err held", 6'o52, 1'b0, 1'b1);
    set_addr(7'h20);
    clr_err = 1'b1;
    step();
    check_word("set beats clr", 6'o01, 1'b1, 1'b1);
    set_addr(7'h35);
    step();
    check_word("clr alone", 6'o52, 1'b0, 1'b0);
    clr_err = 1'b0;

    // 5: back-to-back writes to 0x00..0x03.
    bb_data[0] = 6'o11; bb_par[0] = 1'b1;
    bb_data[1] = 6'o22; bb_par[1] = 1'b1;
    bb_data[2] = 6'o13; bb_par[2] = 1'b0;
    bb_data[3] = 6'o44; bb_par[3] = 1'b1;
    wr_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_addr(i[6:0]);
      ar = bb_data[i];
      step();
    end
    wr_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_addr(i[6:0]);
      step();
      check_word($sformatf("b2b %0d", i), bb_data[i], bb_par[i], 1'b0);
    end

    // 6: leave a bad word showing, then reset mid-scrub.
    set_addr(7'h20);
    step();
    check_word("pre reset", 6'o01, 1'b1, 1'b1);
    #2 reset_l = 1'b0;
    #1;
    check_word("async reset", 6'o00, 1'b1, 1'b0);
    check("async busy", {7'b0, busy}, 8'h01);
    step();
    reset_l = 1'b1;
    repeat (60) step();
    check("scrub60 busy", {7'b0, busy}, 8'h01);
    #2 reset_l = 1'b0;
    #1;
    check_word("mid reset", 6'o00, 1'b1, 1'b0);
    step();
    reset_l = 1'b1;
    count_busy(n);
    check("rescrub edges", n[7:0], 8'd128);
    set_addr(7'h35);
    step();
    check_word("rescrubbed 35", 6'o00, 1'b1, 1'b0);
    set_addr(7'h20);
    step();
    check_word("rescrubbed 20", 6'o00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
